// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared state encoding and BCD constants for bcd_add_seq
package bcd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADD_LO = 3'd1,
    COR_LO = 3'd2,
    ADD_HI = 3'd3,
    COR_HI = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  function automatic logic bad_digit(input logic [3:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/add4.sv
// rtl/add4.sv - 4-bit ripple-carry binary adder, purely combinational
module add4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic [4:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign Sum[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[4];

endmodule

// File: rtl/bcd_add_seq.sv
// rtl/bcd_add_seq.sv - 2-digit packed-BCD adder sharing one 4-bit adder over a 6-state sequence
module bcd_add_seq
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] a_bcd,
  input  logic [7:0] b_bcd,
  input  logic       cin,
  output logic       busy,
  output logic       done,
  output logic [7:0] sum_bcd,
  output logic       cout,
  output logic       err
);

  state_t     state;
  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic       cin_reg;
  logic [4:0] r;
  logic       dcarry;

  logic [3:0] add_a;
  logic [3:0] add_b;
  logic [3:0] add_sum;
  logic       add_cin;
  logic       add_cout;
  logic       corr;
  logic       bad_op;

  assign corr   = r > {1'b0, BCD_MAX};
  assign bad_op = bad_digit(a_reg[3:0]) | bad_digit(a_reg[7:4]) |
                  bad_digit(b_reg[3:0]) | bad_digit(b_reg[7:4]);

  // Operand mux: the only adder in the design is steered by the current state.
  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    case (state)
      ADD_LO: begin
        add_a   = a_reg[3:0];
        add_b   = b_reg[3:0];
        add_cin = cin_reg;
      end
      ADD_HI: begin
        add_a   = a_reg[7:4];
        add_b   = b_reg[7:4];
        add_cin = dcarry;
      end
      COR_LO, COR_HI: begin
        add_a = r[3:0];
        add_b = corr ? BCD_CORR : 4'd0;
      end
      default: ;
    endcase
  end

  add4 u_add4 (
    .A   (add_a),
    .B   (add_b),
    .Cin (add_cin),
    .Sum (add_sum),
    .Cout(add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum_bcd <= 8'h00;
      cout    <= 1'b0;
      err     <= 1'b0;
      a_reg   <= 8'h00;
      b_reg   <= 8'h00;
      cin_reg <= 1'b0;
      r       <= 5'd0;
      dcarry  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= a_bcd;
            b_reg   <= b_bcd;
            cin_reg <= cin;
            sum_bcd <= 8'h00;
            cout    <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b1;
            state   <= ADD_LO;
          end
        end
        ADD_LO: begin
          // Captured digits are screened here so a bad operand never reaches the result.
          if (bad_op) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            r     <= {add_cout, add_sum};
            state <= COR_LO;
          end
        end
        COR_LO: begin
          sum_bcd[3:0] <= add_sum;
          dcarry       <= corr;
          state        <= ADD_HI;
        end
        ADD_HI: begin
          r     <= {add_cout, add_sum};
          state <= COR_HI;
        end
        COR_HI: begin
          sum_bcd[7:4] <= add_sum;
          cout         <= corr;
          done         <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
